// File: rtl/dht22_responder.sv
// DHT22 sensor emulator: answers a qualified host start pulse with a 40-bit humidity/temperature/parity frame.
// Optional DHT22_PARITY_ERR_INJ_EN adds parity_err_inj to corrupt parity bit 0 of the frame being snapshotted.
module dht22_responder #(
    parameter int CLK_FREQ = 100000000
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        dht22_in,
    output logic        dht22_oe,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
`ifdef DHT22_PARITY_ERR_INJ_EN
    input  logic        parity_err_inj,
`endif
    output logic        busy,
    output logic        frame_done
);

    localparam int T_US    = CLK_FREQ / 1000000;
    localparam int CNT_MAX = 2000 * T_US;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] N_QUAL = CW'(1000 * T_US);
    localparam logic [CW-1:0] N_GAP  = CW'(30 * T_US);
    localparam logic [CW-1:0] N_RESP = CW'(80 * T_US);
    localparam logic [CW-1:0] N_BLOW = CW'(50 * T_US);
    localparam logic [CW-1:0] N_ZERO = CW'(26 * T_US);
    localparam logic [CW-1:0] N_ONE  = CW'(70 * T_US);

    typedef enum logic [2:0] {
        IDLE, ARM, WAIT_GAP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    sync_q;
    logic          line_s, line_prev;
    logic [CW-1:0] cnt, dur;
    logic [5:0]    bit_idx;
    logic [39:0]   shreg;
    logic [7:0]    parity;
    logic          tdone, cnt_clr, snap, shift, fd_nxt;

    assign line_s = sync_q[1];
    assign tdone  = (cnt == dur - CW'(1));

    always_comb begin
        parity = humidity[15:8] + humidity[7:0] + temperature[15:8] + temperature[7:0];
`ifdef DHT22_PARITY_ERR_INJ_EN
        parity = parity ^ {7'd0, parity_err_inj};
`endif
    end

    always_comb begin
        case (state)
            RESP_LOW, RESP_HIGH: dur = N_RESP;
            BIT_LOW, END_LOW:    dur = N_BLOW;
            BIT_HIGH:            dur = shreg[39] ? N_ONE : N_ZERO;
            default:             dur = N_GAP;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        snap      = 1'b0;
        shift     = 1'b0;
        fd_nxt    = 1'b0;
        case (state)
            IDLE: if (line_prev && !line_s) begin
                state_nxt = ARM;
                cnt_clr   = 1'b1;
            end
            ARM: if (line_s) begin
                cnt_clr = 1'b1;
                if (cnt >= N_QUAL) begin
                    state_nxt = WAIT_GAP;
                    snap      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_GAP:  if (tdone) begin state_nxt = RESP_LOW;  cnt_clr = 1'b1; end
            RESP_LOW:  if (tdone) begin state_nxt = RESP_HIGH; cnt_clr = 1'b1; end
            RESP_HIGH: if (tdone) begin state_nxt = BIT_LOW;   cnt_clr = 1'b1; end
            BIT_LOW:   if (tdone) begin state_nxt = BIT_HIGH;  cnt_clr = 1'b1; end
            BIT_HIGH: if (tdone) begin
                cnt_clr   = 1'b1;
                shift     = 1'b1;
                state_nxt = (bit_idx == 6'd39) ? END_LOW : BIT_LOW;
            end
            END_LOW: if (tdone) begin
                state_nxt = IDLE;
                cnt_clr   = 1'b1;
                fd_nxt    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            sync_q     <= 2'b11;
            line_prev  <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            dht22_oe   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            sync_q    <= {sync_q[0], dht22_in};
            line_prev <= line_s;
            // ARM saturates so arbitrarily long holds still qualify
            if (cnt_clr || state == IDLE)
                cnt <= '0;
            else if (state != ARM || cnt != {CW{1'b1}})
                cnt <= cnt + CW'(1);
            if (snap) begin
                shreg   <= {humidity, temperature, parity};
                bit_idx <= '0;
            end else if (shift) begin
                shreg   <= {shreg[38:0], 1'b0};
                bit_idx <= bit_idx + 6'd1;
            end
            // Outputs decoded from next state keep them aligned with the state register
            dht22_oe   <= (state_nxt == RESP_LOW) || (state_nxt == BIT_LOW) || (state_nxt == END_LOW);
            busy       <= (state_nxt != IDLE) && (state_nxt != ARM);
            frame_done <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_dht22_responder.sv
// Bench for dht22_responder at 1 MHz (one cycle per microsecond): models the open-drain bus and a host that decodes frames.
module tb_dht22_responder;

    localparam int T = 1;

    logic        clk = 1'b0;
    logic        arst;
    logic        host_low;
    logic        dht_line;
    logic        dut_oe;
    logic [15:0] humidity, temperature;
    logic        busy, frame_done;
`ifdef DHT22_PARITY_ERR_INJ_EN
    logic        parity_err_inj = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic        chg_en  = 1'b0;
    logic [15:0] chg_val = 16'h0;

    assign dht_line = ~(dut_oe | host_low);

    always #5 clk = ~clk;

    dht22_responder #(.CLK_FREQ(1000000)) dut (
        .clk         (clk),
        .arst        (arst),
        .dht22_in    (dht_line),
        .dht22_oe    (dut_oe),
        .humidity    (humidity),
        .temperature (temperature),
`ifdef DHT22_PARITY_ERR_INJ_EN
        .parity_err_inj (parity_err_inj),
`endif
        .busy        (busy),
        .frame_done  (frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame a sensor should send: data words followed by their byte sum
    function automatic logic [39:0] model_word(input logic [15:0] h, input logic [15:0] t, input logic inj);
        int s;
        s = (int'(h) / 256) + (int'(h) % 256) + (int'(t) / 256) + (int'(t) % 256);
        s = (s % 256) ^ int'(inj);
        return {h, t, 8'(s)};
    endfunction

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (dut_oe == lvl && n < 3000) begin
            n++;
            step();
        end
    endtask

    task automatic host_start(input int low_us);
        host_low = 1'b1;
        repeat (low_us * T) step();
        host_low = 1'b0;
    endtask

    task automatic run_frame(input int low_us, input logic [39:0] exp);
        int n;
        logic [39:0] got;
        got = '0;
        host_start(low_us);
        run_len(1'b0, n);
        chk("gap_in_range", (n >= 30 * T && n <= 30 * T + 5), 1);
        chk("busy_in_frame", busy, 1);
        run_len(1'b1, n);
        chk("resp_low", n, 80 * T);
        run_len(1'b0, n);
        chk("resp_high", n, 80 * T);
        if (chg_en) humidity = chg_val;
        for (int i = 0; i < 40; i++) begin
            run_len(1'b1, n);
            chk("bit_low", n, 50 * T);
            run_len(1'b0, n);
            got[39 - i] = (n > 48 * T);
            chk("bit_high", n, exp[39 - i] ? 70 * T : 26 * T);
        end
        run_len(1'b1, n);
        chk("end_low", n, 50 * T);
        chk("frame_done_pulse", frame_done, 1);
        chk("busy_after", busy, 0);
        step();
        chk("frame_done_one_cycle", frame_done, 0);
        chk("frame_word", got, exp);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int n, seen_oe, seen_fd, seen_busy;
        logic [15:0] h0, h1, t0;

        arst = 1'b1;
        host_low = 1'b0;
        humidity = 16'h028C;
        temperature = 16'h015F;
        repeat (3) step();
        chk("rst_oe", dut_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        arst = 1'b0;
        repeat (5) step();

        // reference frame
        run_frame(2000, 40'h028C015FEE);
        repeat (20) step();

        // short pulse must be discarded
        seen_oe = 0; seen_fd = 0; seen_busy = 0;
        host_low = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (i == 500 * T) host_low = 1'b0;
            step();
            seen_oe   += int'(dut_oe);
            seen_fd   += int'(frame_done);
            seen_busy += int'(busy);
        end
        chk("reject_oe", seen_oe, 0);
        chk("reject_frame_done", seen_fd, 0);
        chk("reject_busy", seen_busy, 0);

        // negative temperature, parity E5
        humidity = 16'h0000;
        temperature = 16'h8065;
        run_frame(2000, 40'h00008065E5);
        repeat (20) step();

        // reset during bit 17
        humidity = 16'h028C;
        temperature = 16'h015F;
        host_start(2000);
        run_len(1'b0, n);
        run_len(1'b1, n);
        run_len(1'b0, n);
        for (int i = 0; i < 16; i++) begin
            run_len(1'b1, n);
            run_len(1'b0, n);
        end
        repeat (10) step();
        chk("pre_rst_oe", dut_oe, 1);
        arst = 1'b1;
        #1;
        chk("midrst_oe", dut_oe, 0);
        chk("midrst_busy", busy, 0);
        step();
        arst = 1'b0;
        repeat (200) step();
        chk("post_rst_idle_oe", dut_oe, 0);
        run_frame(2000, 40'h028C015FEE);
        repeat (20) step();

        // mid-frame humidity change, then a saturating long hold picks up the new value
        h0 = 16'($urandom);
        h1 = h0 ^ 16'h5A3C;
        t0 = 16'($urandom);
        humidity = h0;
        temperature = t0;
        chg_en = 1'b1;
        chg_val = h1;
        run_frame(1500, model_word(h0, t0, 1'b0));
        chg_en = 1'b0;
        repeat (20) step();
        run_frame(2600, model_word(h1, t0, 1'b0));
        repeat (20) step();

        // random data and hold lengths
        for (int k = 0; k < 2; k++) begin
            humidity = 16'($urandom);
            temperature = 16'($urandom);
            run_frame(int'($urandom_range(1100, 2200)), model_word(humidity, temperature, 1'b0));
            repeat (int'($urandom_range(5, 50))) step();
        end

`ifdef DHT22_PARITY_ERR_INJ_EN
        humidity = 16'h028C;
        temperature = 16'h015F;
        parity_err_inj = 1'b1;
        run_frame(2000, 40'h028C015FEF);
        parity_err_inj = 1'b0;
        repeat (20) step();
        run_frame(2000, 40'h028C015FEE);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dht22_responder.md
DHT22_RESPONDER -- requirements
Module: dht22_responder

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, meaning clk frequency in Hz; 1 us = CLK_FREQ/1000000 cycles (T_US).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port arst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port dht22_in  input  1  sampled level of the single-wire bus (pulled high when released).
REQ-005 SHALL have port dht22_oe  output  1  1 = pull bus low, 0 = release (open-drain emulation).
REQ-006 SHALL have port humidity  input  16  humidity word to report, x10 fixed point.
REQ-007 SHALL have port temperature  input  16  temperature word to report, bit15 = sign.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE and ARM.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse when a full frame has been sent and the bus released.

Function
REQ-010 SHALL pass dht22_in through a 2-flop synchronizer (reset value 1); all decisions use the synchronized level.
REQ-011 SHALL implement states IDLE, ARM, WAIT_GAP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-012 SHALL go IDLE -> ARM when the synchronized line falls, with the cycle counter cleared.
REQ-013 SHALL, in ARM, count cycles while the line is low; on the line rising, go to WAIT_GAP if the count reached 1000*T_US, otherwise return to IDLE, discarding the glitch.
REQ-014 SHALL, on entering WAIT_GAP, snapshot humidity and temperature and compute parity = (h[15:8]+h[7:0]+t[15:8]+t[7:0]) mod 256 into a 40-bit shift register.
REQ-015 SHALL hold WAIT_GAP for 30*T_US cycles with the bus released, then enter RESP_LOW.
REQ-016 SHALL drive low for 80*T_US in RESP_LOW, then release for 80*T_US in RESP_HIGH.
REQ-017 SHALL send 40 bits MSB first (humidity, temperature, parity); each bit is BIT_LOW 50*T_US driven low, then BIT_HIGH released for 26*T_US ('0') or 70*T_US ('1').
REQ-018 SHALL, after bit 40's high phase, drive END_LOW for 50*T_US, then release, pulse frame_done for one cycle and go to IDLE.
REQ-019 SHALL ignore dht22_in in every state from WAIT_GAP through END_LOW.
REQ-020 SHALL keep dht22_oe registered and glitch-free: 1 only in RESP_LOW, BIT_LOW and END_LOW.
REQ-021 SHALL ignore changes to humidity/temperature after the snapshot until the next frame.
REQ-022 SHALL size the counter for at least 2000*T_US and saturate rather than wrap in ARM, so holds longer than 2 ms still qualify.
REQ-023 SHALL keep frame_done low on a rejected start (REQ-013).

Reset
REQ-024 SHALL, on arst, asynchronously force state IDLE, dht22_oe=0, busy=0, frame_done=0, counter=0, shift register=0 and synchronizer=1.
REQ-025 SHALL release the bus immediately on arst asserted mid-frame and require a fresh qualified start after release.

Configuration
REQ-026 SHALL support macro DHT22_PARITY_ERR_INJ_EN: when defined, adds input port parity_err_inj (1 bit), sampled at snapshot; 1 inverts parity bit 0 for that frame only.
REQ-027 SHALL, with DHT22_PARITY_ERR_INJ_EN undefined, have no parity_err_inj port and always send correct parity.

Verification (CLK_FREQ=100000000)
REQ-028 SHALL pass this scenario: h=0x028C, t=0x015F, host low 2 ms then release -> after 30 us, 80 us low/80 us high response, then bits decoding 0x028C015FEE, frame_done pulse.
REQ-029 SHALL pass this scenario: host low 500 us then release -> stays IDLE, dht22_oe never 1, no frame_done.
REQ-030 SHALL pass this scenario: t=0x8065 (-10.1 C), h=0x0000 -> parity 0xE5, the '1' bit high phase measured 7000 cycles and the '0' bit high phase 2600 cycles.
REQ-031 SHALL pass this scenario: arst pulsed during bit 17 -> dht22_oe=0 the same cycle, busy=0; a new 2 ms start gives a complete, correct frame.
REQ-032 SHALL pass this scenario: humidity changed mid-frame -> transmitted frame carries the snapshot value; the next frame carries the new value.
REQ-033 SHALL pass this scenario: with DHT22_PARITY_ERR_INJ_EN and parity_err_inj=1 on the REQ-028 data -> parity byte 0xEF.
